// File: rtl/cursor_ctrl.sv
// Cursor position controller: samples left/right/clear pulses from an input
// stage, updates a wrapping cursor position, then idles DIV cycles before resampling.
module cursor_ctrl #(
    parameter int POS_W    = 4,
    parameter int POS_MAX  = 15,
    parameter int POS_INIT = 8,
    parameter int DIV      = 1000,
    parameter int DIV_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             clr_i,
    input  logic             d_inp_i,
    output logic             e_inp_o,
    output logic [POS_W-1:0] pos_o,
    output logic             move_o,
    output logic             err_o
);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_UPDATE, S_WAIT} state_t;

    localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_INIT = POS_W'(POS_INIT);
    localparam logic [DIV_W-1:0] W_LOAD = DIV_W'(DIV - 1);

    state_t           r_state, w_next;
    logic [DIV_W-1:0] r_wcnt;
    logic [1:0]       r_tmo;
    logic             r_left, r_right, r_clr;
    logic [POS_W-1:0] w_new_pos;
    logic             w_tmo_hit;

    // Fourth consecutive SAMPLE cycle without valid data
    assign w_tmo_hit = (r_state == S_SAMPLE) && !d_inp_i && (r_tmo == 2'd3);
    assign e_inp_o   = (r_state == S_SAMPLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start_i && !stop_i) w_next = S_SAMPLE;
            S_SAMPLE: begin
                if (stop_i)         w_next = S_IDLE;
                else if (d_inp_i)   w_next = S_UPDATE;
                else if (w_tmo_hit) w_next = S_WAIT;
            end
            S_UPDATE: w_next = stop_i ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (stop_i)              w_next = S_IDLE;
                else if (r_wcnt == '0)   w_next = S_SAMPLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_new_pos = pos_o;
        if (r_clr)
            w_new_pos = P_INIT;
        else if (r_left && !r_right)
            w_new_pos = (pos_o == '0) ? P_MAX : pos_o - POS_W'(1);
        else if (r_right && !r_left)
            w_new_pos = (pos_o == P_MAX) ? '0 : pos_o + POS_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_o   <= P_INIT;
            move_o  <= 1'b0;
            err_o   <= 1'b0;
            r_wcnt  <= '0;
            r_tmo   <= '0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            move_o <= 1'b0;

            if (r_state == S_SAMPLE && w_next == S_UPDATE) begin
                r_left  <= left_i;
                r_right <= right_i;
                r_clr   <= clr_i;
            end

            if (r_state == S_SAMPLE && w_next == S_SAMPLE) r_tmo <= r_tmo + 2'd1;
            else                                           r_tmo <= '0;

            if (w_next == S_WAIT && r_state != S_WAIT)
                r_wcnt <= W_LOAD;
            else if (r_state == S_WAIT && r_wcnt != '0)
                r_wcnt <= r_wcnt - DIV_W'(1);

            // A stop during UPDATE skips this, discarding the pending move
            if (r_state == S_UPDATE && w_next == S_WAIT) begin
                pos_o  <= w_new_pos;
                move_o <= (w_new_pos != pos_o);
            end

            if (w_tmo_hit && w_next == S_WAIT) err_o <= 1'b1;
            if (r_state == S_IDLE && w_next == S_SAMPLE) err_o <= 1'b0;
        end
    end

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameter POS_W, default 4, cursor position width in bits.
REQ-002 Parameter POS_MAX, default 15, highest legal position; must satisfy POS_MAX < 2^POS_W.
REQ-003 Parameter POS_INIT, default 8, position after reset or clear; must satisfy POS_INIT <= POS_MAX.
REQ-004 Parameter DIV, default 1000, idle cycles between sample windows; must be at least 1.
REQ-005 Parameter DIV_W, default 16, width of the wait counter; must satisfy DIV <= 2^DIV_W.
REQ-006 clk_i  in  1  single clock; all logic on posedge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 start_i  in  1  level; leaves IDLE when high.
REQ-009 stop_i  in  1  level; returns to IDLE when high.
REQ-010 left_i  in  1  one-cycle left pulse from input stage.
REQ-011 right_i  in  1  one-cycle right pulse from input stage.
REQ-012 clr_i  in  1  one-cycle clear pulse from input stage.
REQ-013 d_inp_i  in  1  input-stage valid, high when left/right/clr are meaningful.
REQ-014 e_inp_o  out  1  enable to input stage.
REQ-015 pos_o  out  POS_W  current cursor position.
REQ-016 move_o  out  1  one-cycle pulse when pos_o changed.
REQ-017 err_o  out  1  sticky sample-timeout flag.

Function
REQ-018 FSM states: IDLE, SAMPLE, UPDATE, WAIT.
REQ-019 e_inp_o SHALL be 1 exactly while in SAMPLE (Moore output).
REQ-020 IDLE -> SAMPLE on the edge where start_i=1 and stop_i=0.
REQ-021 SAMPLE: the first cycle with d_inp_i=1 latches left_i/right_i/clr_i and moves to UPDATE.
REQ-022 SAMPLE timeout: 4 consecutive SAMPLE cycles without d_inp_i -> set err_o, go to WAIT with no move.
REQ-023 UPDATE lasts exactly 1 cycle, then goes to WAIT.
REQ-024 Position update priority in UPDATE: clr -> POS_INIT; else left-only -> pos-1; else right-only -> pos+1; else unchanged.
REQ-025 Left and right together without clr -> no change.
REQ-026 Wrap-around: left at 0 -> POS_MAX; right at POS_MAX -> 0.
REQ-027 pos_o updates on the edge leaving UPDATE.
REQ-028 move_o is 1 in the first WAIT cycle only when the new pos_o differs from the old value; a clear to the same value gives no pulse.
REQ-029 WAIT: counter loads DIV-1 on entry, decrements each cycle, and moves to SAMPLE on the edge where it reads 0, giving exactly DIV WAIT cycles.
REQ-030 stop_i=1 in SAMPLE, UPDATE or WAIT -> IDLE next edge; pos_o is kept and a pending UPDATE is discarded.
REQ-031 stop_i has priority over start_i when both are high.
REQ-032 err_o clears only on rst_i, or on the IDLE->SAMPLE transition.
REQ-033 Pulses arriving outside SAMPLE, or with d_inp_i=0, are ignored.

Reset
REQ-034 rst_i=1 at an edge forces: state IDLE, pos_o=POS_INIT, e_inp_o=0, move_o=0, err_o=0, wait counter=0, latched inputs=0.
REQ-035 Reset overrides every other input in any state, including mid-WAIT or mid-SAMPLE.

Verification
REQ-036 Reset then start_i=1 -> e_inp_o=1 next cycle; d_inp_i+right_i -> after UPDATE pos_o=9 and move_o pulses once.
REQ-037 pos_o=0 with left_i sampled -> pos_o=15 and move_o=1; pos_o=15 with right_i sampled -> pos_o=0.
REQ-038 left_i+right_i together -> pos_o unchanged, move_o=0; left_i+clr_i with pos_o=3 -> pos_o=8.
REQ-039 Hold d_inp_i=0 in SAMPLE -> err_o=1 after the 4th cycle, WAIT entered, pos_o unchanged; restart from IDLE clears err_o.
REQ-040 DIV=5: count cycles from WAIT entry to the next e_inp_o rise = 5; stop_i mid-WAIT -> IDLE, e_inp_o stays 0.
REQ-041 Assert rst_i during WAIT with pos_o=12 -> next cycle pos_o=8, IDLE, all outputs at reset values.
